// File: rtl/multiplier_middle_bits.sv
// Digit-serial unsigned W x W multiplier: DIGIT multiplier bits per cycle into a full
// 2W-bit accumulator; only the slice acc[OUT_LSB +: OUT_W] is presented on res.
module multiplier_middle_bits #(
   parameter int W       = 56,
   parameter int DIGIT   = 4,
   parameter int OUT_LSB = 56,
   parameter int OUT_W   = 54
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     bi,
   output logic [OUT_W-1:0] res,
   output logic             done
);

   localparam int NDIG = W / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     a_reg, b_reg;
   logic [2*W-1:0]   acc, pp;
   logic [CW-1:0]    cnt;
   logic             last;

   assign last = (cnt == CW'(NDIG - 1));

   // rst_n is active-high despite its name
   always_ff @(posedge clk) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)   state_nxt = BUSY;
         BUSY:    if (last) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Partial product is formed at full 2W width so the shifted add cannot lose bits
   always_comb begin
      pp = ({{W{1'b0}}, a_reg} * {{(2*W-DIGIT){1'b0}}, b_reg[DIGIT-1:0]})
           << (32'(cnt) * 32'(DIGIT));
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
         res   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  a_reg <= a;
                  b_reg <= bi;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               acc   <= acc + pp;
               b_reg <= b_reg >> DIGIT;
               cnt   <= cnt + 1'b1;
            end
            FIN: begin
               res  <= acc[OUT_LSB +: OUT_W];
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_middle_bits.sv
// Bench for multiplier_middle_bits: default middle slice and upper 2-bit variant side by side,
// table of vectors issued back-to-back, scoreboard queue checked on every done pulse.
module tb_multiplier_middle_bits;

   localparam int W = 56;

   logic          clk = 1'b0;
   logic          rst_n, en;
   logic [W-1:0]  a, bi;
   logic [53:0]   res_m;
   logic [1:0]    res_u;
   logic          done_m, done_u;

   multiplier_middle_bits dut_mid (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .bi(bi), .res(res_m), .done(done_m));

   multiplier_middle_bits #(.W(56), .DIGIT(4), .OUT_LSB(110), .OUT_W(2)) dut_up (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .bi(bi), .res(res_u), .done(done_u));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [53:0]  m;
      logic [1:0]   u;
   } vec_t;

   typedef struct {
      logic [53:0] m;
      logic [1:0]  u;
      int          due;
   } exp_t;

   exp_t q[$];
   int   pass_n = 0;
   int   tot_n  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tot_n++;
      if (act === req) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, act, req);
   endtask

   function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] xe, ye;
      xe = {{W{1'b0}}, x};
      ye = {{W{1'b0}}, y};
      return xe * ye;
   endfunction

   // Scoreboard: each done pulse must match the oldest outstanding product and its cycle
   always @(negedge clk) begin : mon
      exp_t e;
      if (done_m || done_u) begin
         if (q.size() == 0) begin
            chk("unexpected_done", {62'b0, done_u, done_m}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("res_mid",    64'(res_m),  64'(e.m));
            chk("res_up",     64'(res_u),  64'(e.u));
            chk("done_cycle", 64'(cyc),    64'(e.due));
            chk("done_mid",   64'(done_m), 64'd1);
            chk("done_up",    64'(done_u), 64'd1);
         end
      end
   end

   // Drives en for exactly one edge; push=0 models an en that must be ignored
   task automatic start(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [53:0] m, input logic [1:0] u, input bit push);
      exp_t e;
      @(negedge clk);
      a  = x;
      bi = y;
      en = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         e.m = m; e.u = u; e.due = cyc + 15;
         q.push_back(e);
      end
      en = 1'b0;
      a  = {$urandom, $urandom};
      bi = {$urandom, $urandom};
   endtask

   task automatic start_model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] p;
      p = prod(x, y);
      start(x, y, p[109:56], p[111:110], 1'b1);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'd0);
      q.delete();
   endtask

   initial begin : wdog
      #100000;
      $display("FAIL watchdog: time %0t limit reached", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t           tbl[$];
      vec_t           v;
      logic [2*W-1:0] p;
      logic [W-1:0]   ones;

      ones = '1;
      tbl.push_back('{56'd1 << 28, 56'd1 << 28, 54'd1, 2'd0});
      tbl.push_back('{ones, ones, 54'h3F_FFFF_FFFF_FFFE, 2'b11});
      tbl.push_back('{56'd1 << 55, 56'd1 << 55, 54'd0, 2'b01});
      tbl.push_back('{56'd0, ones, 54'd0, 2'd0});
      tbl.push_back('{56'd1, 56'd1, 54'd0, 2'd0});
      for (int i = 0; i < 6; i++) begin
         v.a = {$urandom, $urandom};
         v.b = {$urandom, $urandom};
         p   = prod(v.a, v.b);
         v.m = p[109:56];
         v.u = p[111:110];
         tbl.push_back(v);
      end

      // Reset held with en high
      rst_n = 1'b1;
      en    = 1'b1;
      a     = 56'h12345;
      bi    = 56'h6789;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_res_mid", 64'(res_m),  64'd0);
         chk("rst_res_up",  64'(res_u),  64'd0);
         chk("rst_done",    64'(done_m), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("idle_res_mid", 64'(res_m), 64'd0);

      // Table, issued back-to-back at the maximum rate
      foreach (tbl[i]) begin
         start(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].u, 1'b1);
         repeat (15) @(posedge clk);
      end
      drain();

      // en at edge 5 of a product is ignored
      start_model(56'hAB_CDEF_0123_4567, 56'h89_ABCD_EF01_2345);
      repeat (4) @(posedge clk);
      start(ones, ones, 54'd0, 2'd0, 1'b0);
      repeat (10) @(posedge clk);
      start_model(56'h00_FFFF_0000_FFFF, 56'h7F_0000_FFFF_0001);
      drain();

      // Reset at edge 7 aborts the product
      start_model(ones, 56'h55_5555_5555_5555);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      chk("abort_res_mid", 64'(res_m),  64'd0);
      chk("abort_res_up",  64'(res_u),  64'd0);
      chk("abort_done",    64'(done_m), 64'd0);
      repeat (20) @(posedge clk);
      start_model(56'h12_3456_789A_BCDE, 56'hFE_DCBA_9876_5432);
      drain();

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule
